pcs_rx_block_lock: RTL

- Parametrised 10GBASE-R receive synchroniser: the Clause 49 block-lock state machine plus the hi-BER monitor.
- Replaces the fixed slip/sync logic inside the 32-bit receive PCS path.
- Consumes one 2-bit sync header per 66b block from the RX gearbox.
- Drives the PMA bit-slip request, block_lock and hi_ber.
- Thresholds, slip settling time and BER window are parameters, so one block serves both 32b and 64b datapaths and shortened-window simulation.

---
 rtl/pcs_rx_block_lock_pkg.sv | 21 ++
 rtl/pcs_rx_ber_mon.sv | 68 ++++++
 rtl/pcs_rx_block_lock.sv | 128 ++++++++++++
 3 files changed

// File: rtl/pcs_rx_block_lock_pkg.sv
// Shared types for the 10GBASE-R receive synchroniser: sync header codes,
// block-lock FSM state encoding and the header validity helper.
// No logic, no latency, no flow control.
package pcs_rx_block_lock_pkg;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  typedef enum logic [1:0] {
    LOCK_INIT = 2'd0,
    RESET_CNT = 2'd1,
    TEST_SH   = 2'd2,
    SLIP      = 2'd3
  } lock_state_t;

  // 2'b00 and 2'b11 are never legal 64b/66b sync headers.
  function automatic logic sh_bad(input logic [1:0] sh);
    return !((sh == SH_DATA) || (sh == SH_CTRL));
  endfunction

endpackage

// File: rtl/pcs_rx_ber_mon.sv
// Hi-BER monitor: counts invalid sync headers per BER_WIN-block window while locked.
// Latency: hi_ber/ber_cnt update one clk after the header that causes the change.
// Backpressure: none; samples every hdr_vld cycle, cannot stall the gearbox.
//
// Ports: clk/rst (async active-low), hdr/hdr_vld from the gearbox,
//        lock = registered block_lock, lock_nxt = its next value,
//        hi_ber flag, ber_cnt saturating invalid-header count.
module pcs_rx_ber_mon
  import pcs_rx_block_lock_pkg::*;
#(
  parameter int BER_WIN = 19531,
  parameter int BER_MAX = 16,
  parameter int CNT_W   = $clog2(BER_WIN + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] hdr,
  input  logic       hdr_vld,
  input  logic       lock,
  input  logic       lock_nxt,
  output logic       hi_ber,
  output logic [5:0] ber_cnt
);

  // One spare bit so the increment past BER_MAX is representable before saturation.
  localparam int ERR_W = $clog2(BER_MAX + 2);
  localparam logic [CNT_W-1:0] WIN_END = CNT_W'(BER_WIN);
  localparam logic [ERR_W-1:0] ERR_MAX = ERR_W'(BER_MAX);

  logic [CNT_W-1:0] win_cnt, win_inc;
  logic [ERR_W-1:0] ber_err, err_inc;
  logic             bad;

  always_comb begin
    bad     = sh_bad(hdr);
    win_inc = win_cnt + CNT_W'(1);
    err_inc = ber_err + ERR_W'(bad);
  end

  // Clearing keys off lock_nxt so hi_ber and ber_cnt drop in the same cycle
  // as block_lock; counting keys off lock so the header that declares lock
  // is not charged to the first window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_cnt <= '0;
      ber_err <= '0;
      hi_ber  <= 1'b0;
      ber_cnt <= '0;
    end else if (!lock_nxt) begin
      win_cnt <= '0;
      ber_err <= '0;
      hi_ber  <= 1'b0;
      ber_cnt <= '0;
    end else if (lock && hdr_vld) begin
      if (win_inc == WIN_END) begin
        win_cnt <= '0;
        ber_err <= '0;
        hi_ber  <= (err_inc >= ERR_MAX);
      end else begin
        win_cnt <= win_inc;
        ber_err <= (err_inc > ERR_MAX) ? ERR_MAX : err_inc;
        if (err_inc >= ERR_MAX) hi_ber <= 1'b1;
      end
      if (bad && (ber_cnt != 6'h3f)) ber_cnt <= ber_cnt + 6'd1;
    end
  end

endmodule

// File: rtl/pcs_rx_block_lock.sv
// 10GBASE-R block-lock FSM with PMA bit-slip control and hi-BER monitor.
// Latency: block_lock/pma_slip registered, one clk after the deciding header.
// Backpressure: none; headers arriving while not in TEST_SH are dropped.
//
// Ports: clk/rst (async active-low), hdr + hdr_vld per 66b block,
//        force_unlock level hold, pma_slip pulse, block_lock, hi_ber, ber_cnt.
module pcs_rx_block_lock
  import pcs_rx_block_lock_pkg::*;
#(
  parameter int LOCK_CNT    = 64,
  parameter int INVALID_MAX = 16,
  parameter int SLIP_WAIT   = 8,
  parameter int BER_WIN     = 19531,
  parameter int BER_MAX     = 16,
  parameter int CNT_W       = $clog2(BER_WIN + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] hdr,
  input  logic       hdr_vld,
  input  logic       force_unlock,
  output logic       pma_slip,
  output logic       block_lock,
  output logic       hi_ber,
  output logic [5:0] ber_cnt
);

  localparam int SH_W  = $clog2(LOCK_CNT + 1);
  localparam int INV_W = $clog2(INVALID_MAX + 1);
  localparam int WT_W  = $clog2(SLIP_WAIT + 1);
  localparam logic [SH_W-1:0]  SH_END  = SH_W'(LOCK_CNT);
  localparam logic [INV_W-1:0] INV_END = INV_W'(INVALID_MAX);
  localparam logic [WT_W-1:0]  WT_END  = WT_W'(SLIP_WAIT);

  lock_state_t      state, state_nxt;
  logic [SH_W-1:0]  sh_cnt, sh_nxt, sh_inc;
  logic [INV_W-1:0] inv_cnt, inv_nxt, inv_inc;
  logic [WT_W-1:0]  wait_cnt, wait_nxt;
  logic             lock_nxt, slip_nxt, bad;

  always_comb begin
    bad       = sh_bad(hdr);
    sh_inc    = sh_cnt + SH_W'(1);
    inv_inc   = inv_cnt + INV_W'(bad);
    state_nxt = state;
    lock_nxt  = block_lock;
    sh_nxt    = sh_cnt;
    inv_nxt   = inv_cnt;
    wait_nxt  = wait_cnt;

    if (force_unlock) begin
      state_nxt = LOCK_INIT;
      lock_nxt  = 1'b0;
    end else begin
      case (state)
        LOCK_INIT: begin
          lock_nxt  = 1'b0;
          state_nxt = RESET_CNT;
        end
        RESET_CNT: begin
          sh_nxt    = '0;
          inv_nxt   = '0;
          state_nxt = TEST_SH;
        end
        TEST_SH: begin
          if (hdr_vld) begin
            // The current header is counted before the window-end test.
            sh_nxt  = sh_inc;
            inv_nxt = inv_inc;
            if (bad && !block_lock) begin
              state_nxt = SLIP;
            end else if (block_lock && (inv_inc == INV_END)) begin
              lock_nxt  = 1'b0;
              state_nxt = SLIP;
            end else if (sh_inc == SH_END) begin
              if (inv_inc == '0) lock_nxt = 1'b1;
              state_nxt = RESET_CNT;
            end
          end
        end
        SLIP: begin
          // First SLIP cycle carries the pulse, the next SLIP_WAIT cycles
          // cover the PMA slip latency; hdr_vld is not looked at here.
          if (wait_cnt == WT_END) state_nxt = RESET_CNT;
          else                    wait_nxt  = wait_cnt + WT_W'(1);
        end
        default: state_nxt = LOCK_INIT;
      endcase
    end

    slip_nxt = (state_nxt == SLIP) && (state != SLIP);
    if (slip_nxt) wait_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= LOCK_INIT;
      sh_cnt     <= '0;
      inv_cnt    <= '0;
      wait_cnt   <= '0;
      pma_slip   <= 1'b0;
      block_lock <= 1'b0;
    end else begin
      state      <= state_nxt;
      sh_cnt     <= sh_nxt;
      inv_cnt    <= inv_nxt;
      wait_cnt   <= wait_nxt;
      pma_slip   <= slip_nxt;
      block_lock <= lock_nxt;
    end
  end

  pcs_rx_ber_mon #(
    .BER_WIN (BER_WIN),
    .BER_MAX (BER_MAX),
    .CNT_W   (CNT_W)
  ) u_ber_mon (
    .clk      (clk),
    .rst      (rst),
    .hdr      (hdr),
    .hdr_vld  (hdr_vld),
    .lock     (block_lock),
    .lock_nxt (lock_nxt),
    .hi_ber   (hi_ber),
    .ber_cnt  (ber_cnt)
  );

endmodule
